// File: rtl/vel_pkg.sv
// vel_pkg: shared types, constants and the quadrature step decoder for velocity capture.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: vel_state_t (IDLE/ARMED/RUN), quad_ev_t, MAX_PERIOD, quad_decode(prev, curr).
package vel_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} vel_state_t;

  typedef enum logic [1:0] {EV_NONE, EV_FWD, EV_REV, EV_ILLEGAL} quad_ev_t;

  localparam logic [31:0] MAX_PERIOD = 32'hFFFF_FFFF;

  // {A,B} forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic quad_ev_t quad_decode(input logic [1:0] prev, input logic [1:0] curr);
    quad_ev_t ev;
    ev = EV_NONE;
    if (prev != curr) begin
      if ((prev ^ curr) == 2'b11) begin
        ev = EV_ILLEGAL;
      end else begin
        case ({prev, curr})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: ev = EV_FWD;
          default:                                ev = EV_REV;
        endcase
      end
    end
    return ev;
  endfunction

endpackage

// File: rtl/us_timebase.sv
// us_timebase: free-running microsecond timebase (prescaler + 32-bit wrapping counter).
// Latency: us_tick is combinational from the prescaler; now_us steps one clk after us_tick.
// Backpressure: none; runs continuously, only reset clears it.
// Ports: clk, reset (async, active-high) in; us_tick (1-cycle strobe per us), now_us[31:0] out.
module us_timebase #(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic        clk,
  input  logic        reset,
  output logic        us_tick,
  output logic [31:0] now_us
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   now_us_q, now_us_d;

  always_comb begin
    us_tick  = (presc_q == PW'(CLK_PER_US - 1));
    presc_d  = us_tick ? '0 : presc_q + PW'(1);
    now_us_d = us_tick ? now_us_q + 32'd1 : now_us_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      now_us_q <= '0;
    end else begin
      presc_q  <= presc_d;
      now_us_q <= now_us_d;
    end
  end

  assign now_us = now_us_q;

endmodule

// File: rtl/velocity_capture_ctrl.sv
// velocity_capture_ctrl: sync + quadrature-decode encoder pins, timestamp ticks, publish period/direction, flag stall.
// Latency: encoder pin change -> period_valid / err_illegal strobe after SYNC_STAGES+2 clk cycles.
// Backpressure: none; period_valid and err_illegal are single-cycle strobes the consumer must take as they fire.
// Ports: clk, reset (async, active-high), enc_a, enc_b (async pins), clear (sync soft reset) in;
//        period_us[31:0], direction, period_valid, stalled, err_illegal out.
// Build option: define VELOCITY_AVG_EN to publish the average of the last 4 raw periods instead of the raw period.
module velocity_capture_ctrl
  import vel_pkg::*;
#(
  parameter int unsigned CLK_PER_US  = 50,
  parameter int unsigned STALL_US    = 100000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        clear,
  output logic [31:0] period_us,
  output logic        direction,
  output logic        period_valid,
  output logic        stalled,
  output logic        err_illegal
);

  localparam logic [31:0] STALL_LIM = 32'(STALL_US);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [1:0]  prev_q, prev_d, curr_ab;
  quad_ev_t    ev_q, ev_d;
  vel_state_t  state_q, state_d;
  logic [31:0] last_us_q, last_us_d;
  logic        dir_q, dir_d;
  logic [31:0] period_q, period_d;
  logic        direction_q, direction_d;
  logic        valid_q, valid_d;
  logic        stalled_q, stalled_d;
  logic        err_q, err_d;
  logic [31:0] now_us, elapsed;
  logic        tick, tick_dir, publish;
  // Elapsed time is taken from now_us directly, so the per-us strobe has no consumer here.
  logic        us_tick_unused;

  us_timebase #(.CLK_PER_US(CLK_PER_US)) u_timebase (
    .clk    (clk),
    .reset  (reset),
    .us_tick(us_tick_unused),
    .now_us (now_us)
  );

`ifdef VELOCITY_AVG_EN
  logic [31:0] ring_q [4];
  logic [31:0] ring_d [4];
  logic [33:0] sum_q, sum_d, sum_new;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  wr_q, wr_d;
  logic [35:0] recip;
  logic [31:0] avg_period;
`endif

  assign curr_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign elapsed = now_us - last_us_q;  // modulo 2^32, correct across now_us wrap

  always_comb begin
    sync_a_d    = {sync_a_q[SYNC_STAGES-2:0], enc_a};
    sync_b_d    = {sync_b_q[SYNC_STAGES-2:0], enc_b};
    prev_d      = curr_ab;
    ev_d        = quad_decode(prev_q, curr_ab);
    state_d     = state_q;
    last_us_d   = last_us_q;
    dir_d       = dir_q;
    period_d    = period_q;
    direction_d = direction_q;
    stalled_d   = stalled_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    publish     = 1'b0;
    tick        = (ev_q == EV_FWD) || (ev_q == EV_REV);
    tick_dir    = (ev_q == EV_FWD);

    if (clear) begin
      // prev_d already reloads from the synced pins, so no phantom tick follows clear.
      state_d     = IDLE;
      ev_d        = EV_NONE;
      last_us_d   = '0;
      dir_d       = 1'b0;
      period_d    = MAX_PERIOD;
      direction_d = 1'b0;
      stalled_d   = 1'b1;
    end else begin
      err_d = (ev_q == EV_ILLEGAL);
      case (state_q)
        IDLE: begin
          if (tick) begin
            last_us_d = now_us;
            dir_d     = tick_dir;
            state_d   = ARMED;
          end
        end
        default: begin
          // A tick outranks the stall threshold in the same cycle.
          if (tick) begin
            last_us_d = now_us;
            if (tick_dir == dir_q) begin
              publish     = 1'b1;
`ifdef VELOCITY_AVG_EN
              period_d    = avg_period;
`else
              period_d    = elapsed;
`endif
              direction_d = dir_q;
              valid_d     = 1'b1;
              stalled_d   = 1'b0;
              state_d     = RUN;
            end else begin
              dir_d   = tick_dir;
              state_d = ARMED;
            end
          end else if (ev_q == EV_ILLEGAL) begin
            last_us_d = now_us;
            state_d   = ARMED;
          end else if (elapsed >= STALL_LIM) begin
            period_d  = MAX_PERIOD;
            stalled_d = 1'b1;
            valid_d   = 1'b1;
            state_d   = IDLE;
          end
        end
      endcase
    end
  end

`ifdef VELOCITY_AVG_EN
  // Until the ring holds 4 entries, divide by the fill count with a 2^35-scaled reciprocal;
  // the scaling keeps the /3 result exact for every sum a 34-bit accumulator can hold.
  always_comb begin
    ring_d  = ring_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    sum_new = sum_q + 34'(elapsed) - ((cnt_q == 3'd4) ? 34'(ring_q[wr_q]) : 34'd0);
    case (cnt_q)
      3'd0:    recip = 36'h8_0000_0000;
      3'd1:    recip = 36'h4_0000_0000;
      default: recip = 36'h2_AAAA_AAAB;
    endcase
    avg_period = (cnt_q >= 3'd3) ? sum_new[33:2] : 32'((70'(sum_new) * 70'(recip)) >> 35);
    if (state_d != RUN) begin
      sum_d = '0;
      cnt_d = '0;
      wr_d  = '0;
    end else if (publish) begin
      ring_d[wr_q] = elapsed;
      sum_d        = sum_new;
      wr_d         = wr_q + 2'd1;
      if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) ring_q[i] <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      wr_q  <= '0;
    end else begin
      ring_q <= ring_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      prev_q      <= '0;
      ev_q        <= EV_NONE;
      state_q     <= IDLE;
      last_us_q   <= '0;
      dir_q       <= 1'b0;
      period_q    <= MAX_PERIOD;
      direction_q <= 1'b0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      sync_a_q    <= sync_a_d;
      sync_b_q    <= sync_b_d;
      prev_q      <= prev_d;
      ev_q        <= ev_d;
      state_q     <= state_d;
      last_us_q   <= last_us_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      direction_q <= direction_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
      err_q       <= err_d;
    end
  end

  assign period_us    = period_q;
  assign direction    = direction_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;
  assign err_illegal  = err_q;

endmodule
